// File: rtl/l2_xbar_pkg.sv
// Shared constants and types for the L2 request/response crossbar tree.
package l2_xbar_pkg;
    localparam int L2_ADDR_WIDTH = 32;
    localparam int L2_DATA_WIDTH = 64;
    localparam int L2_ID_WIDTH   = L2_DATA_WIDTH / 8;

    // wen encoding on every request channel
    localparam logic WEN_READ  = 1'b1;
    localparam logic WEN_WRITE = 1'b0;

    typedef logic port_sel_t;
    localparam port_sel_t PORT0 = 1'b0;
    localparam port_sel_t PORT1 = 1'b1;
endpackage

// File: rtl/rr_arb_2.sv
// Two-requester round-robin arbiter; priority moves to the loser only when
// both requesters contend and a grant is issued.
module rr_arb_2
    import l2_xbar_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic sel_o
);
    port_sel_t rr_prio_q, rr_prio_d;
    port_sel_t sel;
    logic      both;

    always_comb begin
        both = req0_i & req1_i;
        sel  = both ? rr_prio_q : (req1_i ? PORT1 : PORT0);
        gnt0_o = en_i & req0_i & (sel == PORT0);
        gnt1_o = en_i & req1_i & (sel == PORT1);
        rr_prio_d = rr_prio_q;
        if (en_i && both) rr_prio_d = ~sel;
    end

    assign sel_o = sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_prio_q <= PORT0;
        else        rr_prio_q <= rr_prio_d;
    end
endmodule

// File: rtl/fan_in_req_rr_l2.sv
// 2:1 request fan-in node: round-robin arbitration into a one-entry
// registered output stage that sustains one request per cycle.
module fan_in_req_rr_l2
    import l2_xbar_pkg::*;
#(
    parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int DATA_WIDTH = L2_DATA_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req0_i,
    input  logic [ADDR_WIDTH-1:0] data_add0_i,
    input  logic                  data_wen0_i,
    input  logic [DATA_WIDTH-1:0] data_wdata0_i,
    input  logic [BE_WIDTH-1:0]   data_be0_i,
    input  logic [ID_WIDTH-1:0]   data_ID0_i,
    output logic                  data_gnt0_o,
    input  logic                  data_req1_i,
    input  logic [ADDR_WIDTH-1:0] data_add1_i,
    input  logic                  data_wen1_i,
    input  logic [DATA_WIDTH-1:0] data_wdata1_i,
    input  logic [BE_WIDTH-1:0]   data_be1_i,
    input  logic [ID_WIDTH-1:0]   data_ID1_i,
    output logic                  data_gnt1_o,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_add_o,
    output logic                  data_wen_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    output logic [BE_WIDTH-1:0]   data_be_o,
    output logic [ID_WIDTH-1:0]   data_ID_o,
    input  logic                  data_gnt_i
);
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] add_q, add_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  stage_free;
    logic                  sel;
    logic                  load;

    // Grants are held off while reset is asserted so nothing is accepted
    // into a stage that is being cleared.
    assign stage_free = rst_n & (~req_q | data_gnt_i);

    rr_arb_2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (stage_free),
        .req0_i (data_req0_i),
        .req1_i (data_req1_i),
        .gnt0_o (data_gnt0_o),
        .gnt1_o (data_gnt1_o),
        .sel_o  (sel)
    );

    always_comb begin
        load    = data_gnt0_o | data_gnt1_o;
        req_d   = load | (req_q & ~data_gnt_i);
        add_d   = add_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        id_d    = id_q;
        if (load) begin
            add_d   = (sel == PORT1) ? data_add1_i   : data_add0_i;
            wen_d   = (sel == PORT1) ? data_wen1_i   : data_wen0_i;
            wdata_d = (sel == PORT1) ? data_wdata1_i : data_wdata0_i;
            be_d    = (sel == PORT1) ? data_be1_i    : data_be0_i;
            id_d    = (sel == PORT1) ? data_ID1_i    : data_ID0_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            add_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            id_q    <= '0;
        end else begin
            req_q   <= req_d;
            add_q   <= add_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            id_q    <= id_d;
        end
    end

    assign data_req_o   = req_q;
    assign data_add_o   = add_q;
    assign data_wen_o   = wen_q;
    assign data_wdata_o = wdata_q;
    assign data_be_o    = be_q;
    assign data_ID_o    = id_q;
endmodule

// File: tb/tb_fan_in_req_rr_l2.sv
// Directed vector bench for fan_in_req_rr_l2: one table row per cycle,
// plus hand-written reset sequences.
module tb_fan_in_req_rr_l2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int IW = 8;

    localparam logic [AW-1:0] ADD0 = 32'hA000_00A0;
    localparam logic [AW-1:0] ADD1 = 32'hB000_01B0;
    localparam logic [DW-1:0] WD0  = 64'h0A0A_0A0A_0000_1111;
    localparam logic [DW-1:0] WD1  = 64'h1B1B_1B1B_2222_3333;
    localparam logic [BW-1:0] BE0  = 8'h0F;
    localparam logic [BW-1:0] BE1  = 8'hF0;
    localparam logic [IW-1:0] ID0  = 8'h0A;
    localparam logic [IW-1:0] ID1  = 8'h1B;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, req1, gnt_i;
    logic gnt0, gnt1, req_o, wen_o;
    logic [AW-1:0] add_o;
    logic [DW-1:0] wdata_o;
    logic [BW-1:0] be_o;
    logic [IW-1:0] id_o;

    always #5 clk = ~clk;

    fan_in_req_rr_l2 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_req0_i  (req0),
        .data_add0_i  (ADD0),
        .data_wen0_i  (1'b1),
        .data_wdata0_i(WD0),
        .data_be0_i   (BE0),
        .data_ID0_i   (ID0),
        .data_gnt0_o  (gnt0),
        .data_req1_i  (req1),
        .data_add1_i  (ADD1),
        .data_wen1_i  (1'b0),
        .data_wdata1_i(WD1),
        .data_be1_i   (BE1),
        .data_ID1_i   (ID1),
        .data_gnt1_o  (gnt1),
        .data_req_o   (req_o),
        .data_add_o   (add_o),
        .data_wen_o   (wen_o),
        .data_wdata_o (wdata_o),
        .data_be_o    (be_o),
        .data_ID_o    (id_o),
        .data_gnt_i   (gnt_i)
    );

    typedef struct {
        logic       r0, r1, g;
        logic       e_g0, e_g1, e_req;
        logic [7:0] e_id;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic r0, input logic r1, input logic g,
                           input logic e_g0, input logic e_g1, input logic e_req,
                           input logic [7:0] e_id, input int reps);
        vec_t v;
        v = '{r0: r0, r1: r1, g: g, e_g0: e_g0, e_g1: e_g1, e_req: e_req, e_id: e_id};
        for (int k = 0; k < reps; k++) vecs.push_back(v);
    endtask

    // Payload fields follow from which port's request is in the stage.
    task automatic chk_payload(input string tag, input logic [7:0] e_id);
        chk({tag, ".id"},  id_o, e_id);
        chk({tag, ".add"}, add_o, (e_id == ID0) ? ADD0 : ADD1);
        chk({tag, ".wen"}, wen_o, (e_id == ID0) ? 1'b1 : 1'b0);
        chk({tag, ".wd"},  wdata_o, (e_id == ID0) ? WD0 : WD1);
        chk({tag, ".be"},  be_o, (e_id == ID0) ? BE0 : BE1);
    endtask

    initial begin
        // Rows: r0 r1 g | gnt0 gnt1 req_o id_o (state before the edge)
        add_vec(1,0,1, 1,0,0, 8'h00, 1);  // first grant out of reset
        add_vec(1,1,1, 1,0,1, ID0, 1);    // contention, prio 0
        add_vec(1,1,1, 0,1,1, ID0, 1);
        add_vec(1,1,1, 1,0,1, ID1, 1);
        add_vec(1,1,1, 0,1,1, ID0, 1);
        add_vec(1,1,0, 0,0,1, ID1, 5);    // backpressure, payload holds
        add_vec(1,1,1, 1,0,1, ID1, 1);    // resume, prio still 0
        add_vec(1,1,1, 0,1,1, ID0, 1);
        add_vec(1,1,1, 1,0,1, ID1, 1);    // port0 wins -> prio 1
        add_vec(0,1,1, 0,1,1, ID0, 1);    // single req1, prio unchanged
        add_vec(0,1,1, 0,1,1, ID1, 2);
        add_vec(1,1,1, 0,1,1, ID1, 1);    // port1 wins on retained prio
        add_vec(1,1,1, 1,0,1, ID1, 1);
        add_vec(0,1,1, 0,1,1, ID0, 1);    // drain and refill same cycle
        add_vec(0,0,1, 0,0,1, ID1, 1);    // drain with no new request
        add_vec(0,0,1, 0,0,0, 8'h00, 1);
        add_vec(0,0,0, 0,0,0, 8'h00, 1);
        add_vec(1,0,0, 1,0,0, 8'h00, 1);  // empty stage accepts without gnt_i
        add_vec(0,0,0, 0,0,1, ID0, 1);
        add_vec(0,1,0, 0,0,1, ID0, 1);    // full stage blocks req1
        add_vec(0,1,1, 0,1,1, ID0, 1);
        add_vec(1,1,1, 0,1,1, ID1, 1);    // prio 1 from earlier contention
        add_vec(1,1,1, 1,0,1, ID1, 1);    // leaves prio 1, stage full

        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; gnt_i = 1'b1;
        #1;
        chk("rst.req_o", req_o, 1'b0);
        chk("rst.gnt0", gnt0, 1'b0);
        chk("rst.gnt1", gnt1, 1'b0);
        chk("rst.add", add_o, '0);
        chk("rst.id", id_o, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_o_hold", req_o, 1'b0);
        chk("rst.gnt0_hold", gnt0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; gnt_i = vecs[i].g;
            #1;
            chk($sformatf("v%0d.gnt0", i), gnt0, vecs[i].e_g0);
            chk($sformatf("v%0d.gnt1", i), gnt1, vecs[i].e_g1);
            chk($sformatf("v%0d.req_o", i), req_o, vecs[i].e_req);
            if (vecs[i].e_req) chk_payload($sformatf("v%0d", i), vecs[i].e_id);
            @(negedge clk);
        end

        // Async reset mid-stream: stage full, prio 1
        req0 = 1'b1; req1 = 1'b1; gnt_i = 1'b1;
        #1;
        chk("mid.req_o_before", req_o, 1'b1);
        chk("mid.gnt1_before", gnt1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.req_o_async", req_o, 1'b0);
        chk("mid.gnt0_async", gnt0, 1'b0);
        chk("mid.gnt1_async", gnt1, 1'b0);
        chk("mid.id_async", id_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Priority back to port0 after reset
        chk("post.gnt0", gnt0, 1'b1);
        chk("post.gnt1", gnt1, 1'b0);
        @(negedge clk);
        chk("post.req_o", req_o, 1'b1);
        chk_payload("post", ID0);
        chk("post.gnt1_next", gnt1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fan_in_req_rr_l2.md
# fan_in_req_rr_l2

Request-direction 2:1 fan-in node for the L2 crossbar tree. It arbitrates two upstream request channels round-robin and forwards the winner through a one-entry registered output stage toward the L2 bank or the next tree level. The forwarded ID field carries the routing tag that the response fan-in path uses to steer read data back. The output register breaks the long combinational request path between tree levels while sustaining one request per cycle.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 64, write-data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, DATA_WIDTH/8, routing tag width; passed through unmodified

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- data_req0_i / data_req1_i  in  1  upstream request valid
- data_add0_i / data_add1_i  in  ADDR_WIDTH  address
- data_wen0_i / data_wen1_i  in  1  1 = read, 0 = write
- data_wdata0_i / data_wdata1_i  in  DATA_WIDTH  write data
- data_be0_i / data_be1_i  in  BE_WIDTH  byte enables
- data_ID0_i / data_ID1_i  in  ID_WIDTH  routing tag
- data_gnt0_o / data_gnt1_o  out  1  upstream grant; request accepted this cycle
- data_req_o  out  1  downstream request valid (registered)
- data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o  out  as above  registered payload
- data_gnt_i  in  1  downstream grant

## Operation
- Handshake, both sides: a transfer occurs on a cycle where req and gnt are both high. The requester holds req and payload stable until granted.
- Output stage: one entry, state = data_req_o.
  - Stage is free when data_req_o = 0, or when data_req_o & data_gnt_i (draining this cycle).
- Arbitration (combinational, only when the stage is free):
  - Only one requester active: that port is granted.
  - Both active: the port selected by the rr_prio flop is granted (0 → port0, 1 → port1).
  - At most one data_gntX_o is high per cycle. Both grants are 0 when the stage is not free.
- On a grant, the granted payload is loaded into the output register and data_req_o = 1 next cycle.
- If the stage drains with no new grant, data_req_o goes to 0 next cycle. The payload registers hold their old values (don't-care).
- rr_prio update happens only on a cycle where both requests contend and one is granted. It is then set to point at the loser. Single-request grants leave rr_prio unchanged.
- Starvation bound: a continuously requesting port is granted within 2 free-stage cycles.
- data_ID_o = ID of the granted request, unchanged. No tag bits are added here; port steering of responses is the tag's job.

## Timing
- Reset (async assert, sync deassert by system): data_req_o = 0, rr_prio = 0, payload registers all 0. data_gnt0_o and data_gnt1_o are 0 whenever no request is present.
- Latency: upstream grant in cycle N → data_req_o high in cycle N+1.
- Throughput: 1 request/cycle when data_gnt_i is held high.
- data_gntX_o depends combinationally on data_gnt_i, data_reqX_i and rr_prio. There is no path from data_gnt_i to data_req_o.
- Backpressure: data_req_o = 1 & data_gnt_i = 0 → stage holds its payload, no upstream grants.
- Reset mid-transfer: the buffered request is dropped; data_req_o = 0 immediately on assertion.

## Structure
- Shared package l2_xbar_pkg: default width constants (ADDR_WIDTH, DATA_WIDTH, ID_WIDTH), the read/write encoding constant for wen, and the 1-bit port-select typedef.
- One sub-module: rr_arb_2, containing the 2-requester round-robin arbiter (rr_prio flop, grant logic, update enable).
- Top level: stage-free logic, payload mux and output register.

## Test plan
- Reset: rst_n = 0 with req0 = 1 → data_req_o = 0, data_gnt0_o = 0. Release reset with data_gnt_i = 1 → gnt0 = 1 first cycle, data_req_o = 1 next cycle with add = req0 address.
- Contention: req0 = req1 = 1 continuously, data_gnt_i = 1, ID0 = 8'h0A, ID1 = 8'h1B → data_ID_o sequence 0A,1B,0A,1B…, one grant per cycle.
- Backpressure: stage full, data_gnt_i = 0 for 5 cycles with both reqs up → both gnts 0 and data_add_o stable for 5 cycles. Raise data_gnt_i → forward progress resumes.
- Drain-and-refill same cycle: data_req_o = 1, data_gnt_i = 1, req1 = 1 → gnt1 = 1 that cycle, data_req_o stays 1 with port1 payload.
- Priority retention: contend (port0 wins), then 3 cycles of req1-only, then contend again → port1 wins the second contention? No: rr_prio still = 1 from the first contention, so port1 wins it.
- Async reset mid-stream: assert rst_n low while data_req_o = 1 → data_req_o = 0 before the next clock edge, rr_prio = 0.
